// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the sram-like responder: access sizes, FSM states and
// the byte-lane enable helper that the data-side initiator reuses.
package sram_like_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Wide enough for DELAY (0..15) plus a random extra of 0..3.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Misaligned accesses and size 3 yield no enables; the response is still returned.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: if (!lane[0]) be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: if (lane == 2'b00) be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_like_if.sv
// Sram-like request/response handshake between an initiator (master) and a
// responder (slave).
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing one step per asserted
// step; reusable by any random-stall model.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= seed;
        end else if (step) begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the sram-like handshake: drives a single-port synchronous
// RAM and returns one in-order data_ok pulse per accepted request.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          DELAY   = 0,
    parameter bit          RAND_EN = 1'b0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    sram_like_if.slave        bus,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             first_q;
    logic [31:0]      hold_q;
    logic [15:0]      lfsr;
    logic             accept;
    logic [CNT_W-1:0] wait_cyc;

    // A new request may overlap the RESP cycle of the previous one.
    assign bus.addr_ok = !rst && ((state == ST_IDLE) || (state == ST_RESP));
    assign bus.data_ok = (state == ST_RESP);
    assign accept      = bus.req && bus.addr_ok;

    assign wait_cyc = CNT_W'(DELAY) + (RAND_EN ? CNT_W'(lfsr[1:0]) : CNT_W'(0));

    assign ram_en    = accept;
    assign ram_wen   = (accept && bus.wr) ? byte_enable(bus.size, bus.addr[1:0]) : 4'b0000;
    assign ram_addr  = accept ? bus.addr[ADDR_W+1:2] : '0;
    assign ram_wdata = accept ? bus.wdata : '0;

    // RAM data is live only in the cycle after the read; later cycles replay the capture.
    assign bus.rdata = first_q ? ram_rdata : hold_q;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (accept),
        .seed  (SEED),
        .value (lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            first_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            first_q <= accept && !bus.wr;
            if (first_q) hold_q <= ram_rdata;

            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        if (wait_cyc == '0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= wait_cyc;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.addr[31:ADDR_W+2], lfsr[15:2]};

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Responder (slave) end of the sram-like handshake that the core's inst/data sram-to-sram-like bridges initiate.
- Accepts req/addr_ok requests, drives a single-port synchronous RAM, and returns exactly one data_ok pulse per accepted request, in order.
- Used as the memory-side model behind the inst and data ports in core-level simulation, and as the on-chip RAM front end in FPGA builds.
- Supports configurable and pseudo-random response latency to stress initiator stall logic.

Parameters:
- ADDR_W, 16, RAM word-address width; uses addr[ADDR_W+1:2].
- DELAY, 0, fixed extra wait cycles before data_ok (0..15).
- RAND_EN, 0, 1 adds a per-request extra delay of 0..3 cycles taken from the LFSR.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word
- addr  in  32  byte address
- wdata  in  32  write data, already placed in byte lanes by the initiator
- addr_ok  out  1  request accepted this cycle (when req=1)
- data_ok  out  1  one-cycle response pulse
- rdata  out  32  read word (unshifted), valid while data_ok=1
- ram_en  out  1  RAM access strobe
- ram_wen  out  4  byte write enables
- ram_addr  out  ADDR_W  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en

Behaviour:
- Handshake: a request is accepted in cycle T when req && addr_ok. Inputs are sampled only in that cycle.
- addr_ok = (state==IDLE) || data_ok. Back-to-back throughput is one request per cycle when DELAY=0 and RAND_EN=0.
- RAM drive (combinational from inputs):
  - On accept: ram_en=1, ram_addr=addr[ADDR_W+1:2], ram_wdata=wdata, and ram_wen = byte-enable(size, addr[1:0]) if wr, else 4'b0000.
  - Otherwise: ram_en=0 and ram_wen=0.
- Byte enables:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[0] must be 0; 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
  - size 2: addr[1:0] must be 00; 4'b1111.
  - Misaligned or size 3: wen=0000 (no write), but the response is still returned.
- Latency: total wait W = DELAY + (RAND_EN ? lfsr[1:0] : 0), latched at accept. data_ok pulses in cycle T+1+W.
- States:
  - IDLE: on accept with W=0 go to RESP, otherwise go to WAIT with cnt=W.
  - WAIT: decrement cnt; go to RESP when cnt reaches 1.
  - RESP: data_ok=1. A new accept in this cycle re-enters RESP or WAIT; otherwise return to IDLE.
- rdata:
  - first_q marks cycle T+1; hold_q <= ram_rdata in that cycle.
  - rdata = first_q ? ram_rdata : hold_q.
  - For writes, rdata is don't-care (drive hold_q).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per accepted request; reset value SEED.
- Reset (async):
  - Effect: state=IDLE, cnt=0, first_q=0, hold_q=0, lfsr=SEED.
  - Outputs: data_ok=0, rdata=0; addr_ok=1 after reset deasserts; all ram_* outputs 0 while rst=1.
  - Reset mid-operation: the pending response is dropped, no late data_ok is emitted, and RAM writes already committed remain.
- Ordering:
  - Responses are strictly in acceptance order.
  - At most one request is outstanding, plus one overlapped with its RESP cycle.

Decomposition:
- Shared package: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), state enum, byte-enable function (size, addr[1:0]) -> wen. The data-side initiator's lane logic reuses the same function.
- Sub-module: lfsr16 (clk, rst, step, seed -> value), reusable by other random-stall models.

Test Plan:
- Word write then read, DELAY=0: write 0xDEADBEEF at addr 0x100, then read 0x100 -> data_ok at T+1 each; read rdata=0xDEADBEEF; ram_wen=1111 on the write.
- Byte/half lanes: write byte 0xAA at 0x103 (wdata=0xAA000000), then half 0x1234 at 0x100 (wdata=0x00001234); read 0x100 -> rdata=0xAA??1234 with byte 2 unchanged; wen 1000 then 0011.
- Back-to-back reads, DELAY=0: req held high for 4 cycles at 0x0,0x4,0x8,0xC -> addr_ok=1 every cycle, 4 consecutive data_ok pulses with matching words in order.
- DELAY=3: single read at T -> addr_ok low for T+1..T+3, data_ok only at T+4, rdata equals the word captured at T+1 even if ram_rdata changes afterwards.
- Misaligned write: size=2 at 0x102 -> ram_wen=0000, data_ok still at T+1, memory unchanged on readback.
- Reset mid-wait: DELAY=5, accept at T, assert rst at T+2 -> no data_ok ever appears for that request; addr_ok=1 first cycle after rst deasserts; with RAND_EN=1, the LFSR restarts at 0xACE1 and the delay sequence repeats identically.
